// File: rtl/icache_line_fetch_engine.sv
`default_nettype none
// ============================================================================
// Module      : icache_line_fetch_engine
// Description : Instruction-cache miss engine; requests NLINES consecutive
//               lines per miss, tracks acks by group, snoop abort and retry.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_line_fetch_engine #(
    parameter logic [5:0] CORENO     = 6'd1,
    parameter logic [5:0] CID        = 6'd0,
    parameter int         NLINES     = 2,
    parameter int         LINE_BYTES = 32,
    parameter int         ADRW       = 32,
    parameter int         IDXHI      = 13,
    parameter int         TIMEOUT    = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hit,
    input  logic            tlb_v,
    input  logic [ADRW-1:0] miss_vadr,
    input  logic [ADRW-1:0] miss_padr,
    input  logic [15:0]     miss_asid,
    input  logic            full,
    input  logic            ack,
    input  logic [3:0]      ack_tranid,
    input  logic            snoop_v,
    input  logic [ADRW-1:0] snoop_adr,
    input  logic [5:0]      snoop_cid,
    output logic            req_v,
    output logic [3:0]      req_tranid,
    output logic [ADRW-1:0] req_vadr,
    output logic [ADRW-1:0] req_padr,
    output logic [15:0]     req_asid,
    output logic [5:0]      req_core,
    output logic [5:0]      req_cid,
    output logic            vtag_we,
    output logic [3:0]      vtag_idx,
    output logic [ADRW-1:0] vtag_adr,
    output logic            busy
);

    localparam int              c_LOBIT      = $clog2(LINE_BYTES);
    localparam int              c_WW         = $clog2(TIMEOUT + 1);
    localparam logic [ADRW-1:0] c_STEP       = ADRW'(LINE_BYTES);
    localparam logic [ADRW-1:0] c_AMASK      = ~ADRW'(LINE_BYTES - 1);
    localparam logic [1:0]      c_LINE_LAST  = 2'(NLINES - 1);
    localparam logic [2:0]      c_NL         = 3'(NLINES);
    localparam logic [7:0]      c_START_LAST = 8'(4 * CID + 3);
    localparam logic [c_WW-1:0] c_WAIT_LAST  = c_WW'(TIMEOUT - 1);
    localparam logic [c_WW-1:0] c_WAIT_ONE   = c_WW'(1);
    localparam logic [16:0]     c_LFSR_SEED  = 17'h1;

    localparam logic [2:0] c_S_RESET   = 3'd0;
    localparam logic [2:0] c_S_IDLE    = 3'd1;
    localparam logic [2:0] c_S_ISSUE   = 3'd2;
    localparam logic [2:0] c_S_GAP     = 3'd3;
    localparam logic [2:0] c_S_WAIT    = 3'd4;
    localparam logic [2:0] c_S_UPD     = 3'd5;
    localparam logic [2:0] c_S_BACKOFF = 3'd6;

    logic [2:0]             r_state;
    logic [2:0]             w_state_nxt;
    logic [7:0]             r_start;
    logic [16:0]            r_lfsr;
    logic [1:0]             r_group;
    logic [1:0]             r_line;
    logic [2:0]             r_ack_cnt;
    logic [c_WW-1:0]        r_wait;
    logic [4:0]             r_boff;
    logic [ADRW-1:0]        r_vadr;
    logic [ADRW-1:0]        r_padr;
    logic [15:0]            r_asid;
    logic [IDXHI:c_LOBIT]   r_base_idx;
    logic                   w_snoop_hit;
    logic                   w_ack_hit;
    logic [2:0]             w_ack_next;
    logic                   w_issue;
    logic                   w_unused;

    // Index compare uses the miss base, not the advancing line pointer
    assign w_snoop_hit = snoop_v && (snoop_adr[IDXHI:c_LOBIT] == r_base_idx) && (snoop_cid != CID);
    assign w_ack_hit   = ack && (ack_tranid[3:2] == r_group);
    assign w_ack_next  = r_ack_cnt + 3'd1;
    assign w_unused    = ^{snoop_adr, ack_tranid[1:0]};

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_S_RESET;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_RESET: if (r_start == c_START_LAST) w_state_nxt = c_S_IDLE;
            c_S_IDLE:  if (!hit && tlb_v) w_state_nxt = c_S_ISSUE;
            c_S_ISSUE: begin
                if (w_snoop_hit)  w_state_nxt = c_S_BACKOFF;
                else if (!full)   w_state_nxt = (r_line == c_LINE_LAST) ? c_S_WAIT : c_S_GAP;
            end
            c_S_GAP:   w_state_nxt = w_snoop_hit ? c_S_BACKOFF : c_S_ISSUE;
            c_S_WAIT: begin
                if (w_snoop_hit)                           w_state_nxt = c_S_BACKOFF;
                else if (w_ack_hit && (w_ack_next == c_NL)) w_state_nxt = c_S_UPD;
                else if (r_wait == c_WAIT_LAST)            w_state_nxt = c_S_BACKOFF;
            end
            c_S_UPD:     w_state_nxt = c_S_IDLE;
            c_S_BACKOFF: if (r_boff <= 5'd1) w_state_nxt = c_S_IDLE;
            default:     w_state_nxt = c_S_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_start    <= '0;
            r_lfsr     <= c_LFSR_SEED;
            r_group    <= '0;
            r_line     <= '0;
            r_ack_cnt  <= '0;
            r_wait     <= '0;
            r_boff     <= '0;
            r_vadr     <= '0;
            r_padr     <= '0;
            r_asid     <= '0;
            r_base_idx <= '0;
        end else begin
            if (r_state != c_S_RESET) r_lfsr <= {r_lfsr[15:0], r_lfsr[16] ^ r_lfsr[13]};
            case (r_state)
                c_S_RESET: r_start <= r_start + 8'd1;
                c_S_IDLE: begin
                    if (w_state_nxt == c_S_ISSUE) begin
                        r_vadr     <= miss_vadr & c_AMASK;
                        r_padr     <= miss_padr & c_AMASK;
                        r_asid     <= miss_asid;
                        r_base_idx <= miss_padr[IDXHI:c_LOBIT];
                        r_line     <= '0;
                        r_ack_cnt  <= '0;
                    end
                end
                c_S_ISSUE: begin
                    if ((w_state_nxt == c_S_GAP) || (w_state_nxt == c_S_WAIT)) begin
                        r_vadr <= r_vadr + c_STEP;
                        r_padr <= r_padr + c_STEP;
                        r_line <= r_line + 2'd1;
                        r_wait <= '0;
                    end
                end
                c_S_WAIT: begin
                    r_wait <= r_wait + c_WAIT_ONE;
                    if (w_ack_hit) r_ack_cnt <= w_ack_next;
                end
                // Group 0 is only ever used straight out of reset
                c_S_UPD:     r_group <= (r_group == 2'd3) ? 2'd1 : r_group + 2'd1;
                c_S_BACKOFF: r_boff <= r_boff - 5'd1;
                default: ;
            endcase
            if ((w_state_nxt == c_S_BACKOFF) && (r_state != c_S_BACKOFF))
                r_boff <= {1'b0, r_lfsr[3:0]} + 5'd1;
        end
    end

    assign w_issue    = (r_state == c_S_ISSUE);
    assign req_v      = w_issue;
    assign req_tranid = w_issue ? {r_group, r_line} : 4'd0;
    assign req_vadr   = w_issue ? r_vadr : '0;
    assign req_padr   = w_issue ? r_padr : '0;
    assign req_asid   = w_issue ? r_asid : 16'd0;
    assign req_core   = CORENO;
    assign req_cid    = CID;
    assign vtag_we    = w_issue;
    assign vtag_idx   = req_tranid;
    assign vtag_adr   = req_vadr;
    assign busy       = (r_state != c_S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_icache_line_fetch_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_line_fetch_engine
// Description : Self-checking bench: vector table, randomized misses against
//               a transaction-level model, and multi-cycle corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_line_fetch_engine;

    localparam int         NL     = 2;
    localparam logic [5:0] CID_TB = 6'd0;

    logic        clk = 1'b0;
    logic        rst, hit, tlb_v, tlb_v4, full, ack, snoop_v;
    logic [31:0] miss_vadr, miss_padr, snoop_adr;
    logic [15:0] miss_asid;
    logic [3:0]  ack_tranid;
    logic [5:0]  snoop_cid;

    logic        req_v, vtag_we, busy;
    logic [3:0]  req_tranid, vtag_idx;
    logic [31:0] req_vadr, req_padr, vtag_adr;
    logic [15:0] req_asid;
    logic [5:0]  req_core, req_cid;

    logic        req_v4, vtag_we4, busy4;
    logic [3:0]  req_tranid4, vtag_idx4;
    logic [31:0] req_vadr4, req_padr4, vtag_adr4;
    logic [15:0] req_asid4;
    logic [5:0]  req_core4, req_cid4;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [1:0]  m_group  = 2'd0;

    always #5 clk = ~clk;

    icache_line_fetch_engine #(.CORENO(6'd1), .CID(CID_TB), .NLINES(NL), .LINE_BYTES(32),
                               .ADRW(32), .IDXHI(13), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .hit(hit), .tlb_v(tlb_v), .miss_vadr(miss_vadr),
        .miss_padr(miss_padr), .miss_asid(miss_asid), .full(full), .ack(ack),
        .ack_tranid(ack_tranid), .snoop_v(snoop_v), .snoop_adr(snoop_adr),
        .snoop_cid(snoop_cid), .req_v(req_v), .req_tranid(req_tranid),
        .req_vadr(req_vadr), .req_padr(req_padr), .req_asid(req_asid),
        .req_core(req_core), .req_cid(req_cid), .vtag_we(vtag_we),
        .vtag_idx(vtag_idx), .vtag_adr(vtag_adr), .busy(busy));

    icache_line_fetch_engine #(.CORENO(6'd1), .CID(CID_TB), .NLINES(4), .LINE_BYTES(64),
                               .ADRW(32), .IDXHI(13), .TIMEOUT(8)) dut4 (
        .clk(clk), .rst(rst), .hit(hit), .tlb_v(tlb_v4), .miss_vadr(miss_vadr),
        .miss_padr(miss_padr), .miss_asid(miss_asid), .full(full), .ack(ack),
        .ack_tranid(ack_tranid), .snoop_v(snoop_v), .snoop_adr(snoop_adr),
        .snoop_cid(snoop_cid), .req_v(req_v4), .req_tranid(req_tranid4),
        .req_vadr(req_vadr4), .req_padr(req_padr4), .req_asid(req_asid4),
        .req_core(req_core4), .req_cid(req_cid4), .vtag_we(vtag_we4),
        .vtag_idx(vtag_idx4), .vtag_adr(vtag_adr4), .busy(busy4));

    typedef struct {
        logic [31:0] va;
        logic [31:0] pa;
        logic [15:0] asid;
        int          stall;
        logic [31:0] eva0;
        logic [31:0] eva1;
        logic [31:0] epa0;
        logic [31:0] epa1;
        logic [1:0]  grp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_req(input string tag, input logic [31:0] va, input logic [31:0] pa,
                             input logic [15:0] asid, input logic [3:0] tid);
        chk({tag, ".req_v"},    req_v, 1);
        chk({tag, ".vadr"},     req_vadr, va);
        chk({tag, ".padr"},     req_padr, pa);
        chk({tag, ".asid"},     req_asid, asid);
        chk({tag, ".tranid"},   req_tranid, tid);
        chk({tag, ".vtag_we"},  vtag_we, 1);
        chk({tag, ".vtag_idx"}, vtag_idx, tid);
        chk({tag, ".vtag_adr"}, vtag_adr, va);
        chk({tag, ".core_cid"}, {req_core, req_cid}, {6'd1, CID_TB});
    endtask

    // Entered with the DUT presenting a request; leaves one edge after acceptance
    task automatic issue_line(input string tag, input logic [31:0] va, input logic [31:0] pa,
                              input logic [15:0] asid, input logic [3:0] tid, input int stall);
        check_req(tag, va, pa, asid, tid);
        for (int s = 0; s < stall; s++) begin
            full = 1'b1;
            tick();
            check_req({tag, ".held"}, va, pa, asid, tid);
        end
        full = 1'b0;
        tick();
    endtask

    task automatic issue_group(input string tag, input logic [31:0] va, input logic [31:0] pa,
                               input logic [15:0] asid, input int stall, input bit noisy,
                               input logic [31:0] eva0, input logic [31:0] eva1,
                               input logic [31:0] epa0, input logic [31:0] epa1,
                               input logic [1:0] grp);
        chk({tag, ".idle"}, busy, 0);
        miss_vadr = va; miss_padr = pa; miss_asid = asid;
        hit = 1'b0; tlb_v = 1'b1;
        tick();
        tlb_v = 1'b0; hit = 1'b1;
        miss_vadr = ~va; miss_padr = ~pa; miss_asid = ~asid;
        issue_line({tag, ".l0"}, eva0, epa0, asid, {grp, 2'd0}, stall);
        chk({tag, ".gap_v"}, req_v, 0);
        chk({tag, ".gap_busy"}, busy, 1);
        if (noisy) begin
            ack = 1'b1; ack_tranid = {grp, 2'd0};
            snoop_v = 1'b1; snoop_adr = pa; snoop_cid = CID_TB;
        end
        tick();
        ack = 1'b0; snoop_v = 1'b0;
        issue_line({tag, ".l1"}, eva1, epa1, asid, {grp, 2'd1}, noisy ? int'($urandom_range(0, 2)) : 0);
    endtask

    task automatic ack_group(input string tag, input logic [1:0] grp, input bit noisy);
        int first;
        logic [1:0] other;
        first = int'($urandom_range(0, 1));
        for (int j = 0; j < NL; j++) begin
            if (noisy && ($urandom_range(0, 1) == 1)) begin
                other = grp + 2'($urandom_range(1, 3));
                ack = 1'b1; ack_tranid = {other, 2'(j)};
                chk({tag, ".stale_busy"}, busy, 1);
                tick();
            end
            ack = 1'b1; ack_tranid = {grp, 2'((j + first) % NL)};
            chk({tag, ".wait_busy"}, busy, 1);
            chk({tag, ".wait_v"}, req_v, 0);
            tick();
        end
        ack = 1'b0;
        chk({tag, ".upd_busy"}, busy, 1);
        tick();
        chk({tag, ".idle_busy"}, busy, 0);
        m_group = (grp == 2'd3) ? 2'd1 : grp + 2'd1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vec [4];
        logic [31:0] va, pa, eva, epa, e4 [4];
        logic [15:0] asid;
        logic [1:0]  g;
        int          n;

        vec[0] = '{32'h0000_1234, 32'h8001_1234, 16'h00A5, 0,
                   32'h0000_1220, 32'h0000_1240, 32'h8001_1220, 32'h8001_1240, 2'd0};
        vec[1] = '{32'h0000_5678, 32'h0000_9ABC, 16'h1111, 3,
                   32'h0000_5660, 32'h0000_5680, 32'h0000_9AA0, 32'h0000_9AC0, 2'd1};
        vec[2] = '{32'hFFFF_FFF5, 32'h7FFF_FFE1, 16'hFFFF, 1,
                   32'hFFFF_FFE0, 32'h0000_0000, 32'h7FFF_FFE0, 32'h8000_0000, 2'd2};
        vec[3] = '{32'h0000_003F, 32'h1000_0020, 16'h0001, 0,
                   32'h0000_0020, 32'h0000_0040, 32'h1000_0020, 32'h1000_0040, 2'd3};
        e4[0] = 32'hFFFF_FFC0; e4[1] = 32'h0000_0000; e4[2] = 32'h0000_0040; e4[3] = 32'h0000_0080;

        rst = 1'b1; hit = 1'b1; tlb_v = 1'b0; tlb_v4 = 1'b0; full = 1'b0; ack = 1'b0;
        ack_tranid = 4'd0; snoop_v = 1'b0; snoop_adr = '0; snoop_cid = '0;
        miss_vadr = '0; miss_padr = '0; miss_asid = '0;
        repeat (3) tick();
        chk("reset.req_v", req_v, 0);
        chk("reset.busy", busy, 1);
        chk("reset.tranid", req_tranid, 0);
        chk("reset.addr", {req_vadr, req_padr}, 64'h0);
        chk("reset.asid_vtag", {req_asid, vtag_we}, 0);
        rst = 1'b0;
        repeat (3) tick();
        chk("startup.busy_3", busy, 1);
        tick();
        chk("startup.idle", busy, 0);
        chk("startup.idle4", busy4, 0);

        hit = 1'b1; tlb_v = 1'b1;
        tick();
        chk("hit_no_miss.busy", busy, 0);
        tlb_v = 1'b0; hit = 1'b0;
        tick();
        chk("no_tlb.busy", busy, 0);
        hit = 1'b1;

        for (int i = 0; i < 4; i++) begin
            chk($sformatf("vec%0d.model_group", i), vec[i].grp, m_group);
            issue_group($sformatf("vec%0d", i), vec[i].va, vec[i].pa, vec[i].asid, vec[i].stall, 1'b0,
                        vec[i].eva0, vec[i].eva1, vec[i].epa0, vec[i].epa1, vec[i].grp);
            ack_group($sformatf("vec%0d", i), vec[i].grp, 1'b0);
        end

        for (int i = 0; i < 12; i++) begin
            va = $urandom; pa = $urandom; asid = 16'($urandom);
            eva = va - (va % 32);
            epa = pa - (pa % 32);
            issue_group($sformatf("rnd%0d", i), va, pa, asid, int'($urandom_range(0, 2)), 1'b1,
                        eva, eva + 32, epa, epa + 32, m_group);
            ack_group($sformatf("rnd%0d", i), m_group, 1'b1);
        end

        // Foreign snoop hitting the line index during the gap aborts the group
        g = m_group;
        va = 32'h0000_4321; pa = 32'h0004_6789; asid = 16'h0BAD;
        miss_vadr = va; miss_padr = pa; miss_asid = asid; hit = 1'b0; tlb_v = 1'b1;
        tick();
        tlb_v = 1'b0; hit = 1'b1;
        check_req("snp.l0", 32'h0000_4320, 32'h0004_6780, asid, {g, 2'd0});
        tick();
        chk("snp.gap", req_v, 0);
        snoop_v = 1'b1; snoop_adr = (pa & 32'h0000_3FE0) | 32'hFFFF_C01F; snoop_cid = 6'd3;
        tick();
        snoop_v = 1'b0;
        chk("snp.abort_v", req_v, 0);
        chk("snp.abort_busy", busy, 1);
        n = 0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (!busy) begin n = k; break; end
        end
        chk("snp.backoff_len_1_16", (n >= 1) && (n <= 16), 1);
        snoop_v = 1'b1; snoop_cid = 6'd3;
        tick();
        snoop_v = 1'b0;
        chk("snp.idle_snoop_ignored", {busy, req_v}, 2'b00);
        issue_group("snp.retry", va, pa, asid, 0, 1'b0, 32'h0000_4320, 32'h0000_4340,
                    32'h0004_6780, 32'h0004_67A0, g);
        ack_group("snp.retry", g, 1'b0);

        // No acks of the right group: timeout, backoff, then same group again
        g = m_group;
        va = 32'h00AB_CD40; pa = 32'h0012_3440; asid = 16'h7777;
        issue_group("to", va, pa, asid, 0, 1'b0, va, va + 32, pa, pa + 32, g);
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            ack = 1'b1; ack_tranid = {g + 2'd1, 2'(k)};
            chk("to.no_req", req_v, 0);
            tick();
            if (!busy) begin n = k; break; end
        end
        ack = 1'b0;
        chk("to.cycles_9_24", (n >= 9) && (n <= 24), 1);
        issue_group("to.retry", va, pa, asid, 0, 1'b0, va, va + 32, pa, pa + 32, g);
        ack_group("to.retry", g, 1'b1);

        // Reset in the middle of WAIT_ACK
        va = 32'h0000_0100; pa = 32'h0000_0200; asid = 16'h0042;
        issue_group("mrst", va, pa, asid, 0, 1'b0, va, va + 32, pa, pa + 32, m_group);
        rst = 1'b1; ack = 1'b1; ack_tranid = {m_group, 2'd0};
        tick();
        rst = 1'b0; ack_tranid = 4'd1;
        chk("mrst.req_v", req_v, 0);
        chk("mrst.busy", busy, 1);
        repeat (3) tick();
        chk("mrst.startup_busy", busy, 1);
        tick();
        ack = 1'b0;
        chk("mrst.idle", busy, 0);
        m_group = 2'd0;
        issue_group("mrst.after", va, pa, asid, 0, 1'b0, va, va + 32, pa, pa + 32, 2'd0);
        ack_group("mrst.after", 2'd0, 1'b0);
        chk("mrst.group_model", m_group, 2'd1);

        // Four 64-byte lines with address wraparound
        miss_vadr = 32'hFFFF_FFC0; miss_padr = 32'h0000_2000; miss_asid = 16'h4444;
        hit = 1'b0; tlb_v4 = 1'b1;
        tick();
        tlb_v4 = 1'b0; hit = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("w4.l%0d.req_v", k), req_v4, 1);
            chk($sformatf("w4.l%0d.vadr", k), req_vadr4, e4[k]);
            chk($sformatf("w4.l%0d.padr", k), req_padr4, 32'h0000_2000 + 32'(64 * k));
            chk($sformatf("w4.l%0d.tranid", k), req_tranid4, {2'd0, 2'(k)});
            chk($sformatf("w4.l%0d.vtag", k), {vtag_we4, vtag_idx4, vtag_adr4}, {1'b1, 2'd0, 2'(k), e4[k]});
            chk($sformatf("w4.l%0d.misc", k), {req_asid4, req_core4, req_cid4}, {16'h4444, 6'd1, CID_TB});
            tick();
            if (k < 3) begin
                chk($sformatf("w4.gap%0d", k), req_v4, 0);
                tick();
            end
        end
        for (int k = 0; k < 4; k++) begin
            ack = 1'b1; ack_tranid = {2'd0, 2'(3 - k)};
            chk($sformatf("w4.wait%0d", k), {busy4, req_v4}, 2'b10);
            tick();
        end
        ack = 1'b0;
        chk("w4.upd", busy4, 1);
        tick();
        chk("w4.idle", busy4, 0);
        chk("w4.other_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
